disp_scheduler: RTL and testbench
=================================

# disp_scheduler

Time-shares the board's single 8-bit 7-segment display path among up to N requesters. Each requester presents an 8-bit value and a format bit (signed decimal or hex). The block grants one requester at a time in round-robin order, holds each for a fixed dwell time, and drives the selected value and format to the downstream decimal/hex display decoders. It sits between system producers (registers, ALU result, PC, etc.) and the display decode logic. An optional advance pulse from a debounced, falling-edge-detected key forces an early switch.

## Interface
- N_REQ, 4, number of requesters (2..8)
- HOLD_CYCLES, 50_000_000, dwell per grant in clk cycles (1 s at 50 MHz); must be ≥ 2
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester display request, level
- hex_mode  input  N_REQ  per-requester format: 1 = hex, 0 = signed 2's-complement decimal
- data  input  8*N_REQ  requester i value in data[8*i+7:8*i]
- advance  input  1  single-cycle pulse: end current dwell now
- grant  output  N_REQ  one-hot current owner; all zero when idle
- disp_val  output  8  value to display
- disp_hex  output  1  format of disp_val
- disp_en  output  1  display enable; 0 blanks all digits
- dwell_cnt  output  $clog2(HOLD_CYCLES)  current dwell count (debug)

## Operation
- One clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: grant=0, disp_val=0, disp_hex=0, disp_en=0, dwell_cnt=0. The round-robin pointer resets to N_REQ-1, so index 0 has first priority.
- States:
  - IDLE: disp_en=0 and grant=0. If any req bit is set, pick the winner, go to SHOW, and clear dwell_cnt.
  - SHOW: dwell_cnt increments each cycle. An end-of-dwell event is any of:
    - dwell_cnt==HOLD_CYCLES-1,
    - advance=1,
    - req of the current owner is 0.
- Winner selection: the first set req bit scanning upward from pointer+1, wrapping modulo N_REQ. On a grant, pointer becomes the winner's index.
- On end-of-dwell:
  - Re-run selection with the current owner's req included; the owner is last in priority.
  - If there is a winner (possibly the same owner): re-grant it and clear dwell_cnt to 0.
  - If there is none: go to IDLE.
- Display datapath: while in SHOW, disp_val and disp_hex are reloaded every cycle from the owner's data and hex_mode. This gives live tracking with 1 cycle of lag. In IDLE they hold their last values; disp_en=0 blanks the display.
- Simultaneous events (advance together with expiry, owner drop, or any combination) produce exactly one re-arbitration, never two.
- advance while in IDLE is ignored.
- dwell_cnt never exceeds HOLD_CYCLES-1 and never wraps.
- grant is always zero or one-hot.

## Timing
- req rises at edge k in IDLE → grant, disp_en=1, disp_val and disp_hex are all valid after edge k+1 (latency 1).
- Without advance or owner drop, a grant lasts exactly HOLD_CYCLES cycles. The next grant appears at the edge after dwell_cnt==HOLD_CYCLES-1, with no blank cycle between owners.
- advance sampled high at edge k → new grant (or IDLE) after edge k+1.
- Owner's req falls at edge k → its grant is removed after edge k+1.
- The data-to-disp_val lag is 1 cycle.
- reset_n low clears all state immediately, independent of clk, including mid-dwell. Operation resumes at the first clk edge after deassertion. reset_n deassertion is synchronised externally.

## Test plan
Directed scenarios use N_REQ=4 and HOLD_CYCLES=8.

1. **Reset:** assert reset_n=0 mid-SHOW → grant=0, disp_en=0, disp_val=0 immediately. Release with req=4'b0001 → grant=0001 one cycle later.
2. **Round-robin:** req=4'b1011 with data 0x11/0x22/–/0x44 → grant order 0001, 0010, 1000, 0001. Each grant lasts 8 cycles; disp_val follows 0x11, 0x22, 0x44, 0x11.
3. **Advance pulse:** req=4'b0011 held; pulse advance at dwell_cnt=3 → next edge grant=0010 and dwell_cnt=0. Pulse advance together with dwell_cnt=7 → single switch only.
4. **Sole requester / drop:**
   - req=4'b0100 alone → the grant stays 0100 across expiries, with dwell_cnt restarting at 0.
   - Drop req → next edge IDLE, disp_en=0.
5. **Format and live data:** owner with hex_mode=1 and data stepping 0x7F→0x80 → disp_hex=1 and disp_val=0x80 one cycle after the change. Switch to an owner with hex_mode=0 and data 0xF6 (−10) → disp_hex=0, disp_val=0xF6.
6. **Idle noise:** advance pulses with req=0 → outputs stay at their reset values, and no grant is ever issued.

Source files
------------

// File: rtl/disp_scheduler.sv
// Round-robin time-sharing of one 7-segment display path among N_REQ requesters.
// Each grant is held for HOLD_CYCLES clocks or ended early by advance or an owner drop.
module disp_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               hex_mode,
  input  logic [8*N_REQ-1:0]             data,
  input  logic                           advance,
  output logic [N_REQ-1:0]               grant,
  output logic [7:0]                     disp_val,
  output logic                           disp_hex,
  output logic                           disp_en,
  output logic [$clog2(HOLD_CYCLES)-1:0] dwell_cnt
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(HOLD_CYCLES);
  localparam logic [CntW-1:0]  CntLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e          state_q;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand;
  logic            win_found;
  logic            dwell_end;
  int unsigned     idx;

  // Scan upward from ptr_q+1; in SHOW ptr_q is the owner, so it naturally ranks last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx  = (int'(ptr_q) + k) % N_REQ;
      cand = IdxW'(idx);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign dwell_end = (dwell_cnt == CntLast) || advance || !req[ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ptr_q     <= IdxW'(N_REQ - 1);
      grant     <= '0;
      disp_val  <= '0;
      disp_hex  <= 1'b0;
      disp_en   <= 1'b0;
      dwell_cnt <= '0;
    end else if (state_q == StShow && !dwell_end) begin
      dwell_cnt <= dwell_cnt + CntW'(1);
      disp_val  <= data[{ptr_q, 3'b000} +: 8];
      disp_hex  <= hex_mode[ptr_q];
    end else if (win_found) begin
      // Fresh grant from IDLE or a single re-arbitration at end of dwell.
      state_q   <= StShow;
      ptr_q     <= win_idx;
      grant     <= OneHot0 << win_idx;
      disp_val  <= data[{win_idx, 3'b000} +: 8];
      disp_hex  <= hex_mode[win_idx];
      disp_en   <= 1'b1;
      dwell_cnt <= '0;
    end else begin
      state_q   <= StIdle;
      grant     <= '0;
      disp_en   <= 1'b0;
      dwell_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench for disp_scheduler (N_REQ=4, HOLD_CYCLES=8): directed scenarios
// plus randomized traffic compared against a cycle-level behavioural model.
module tb_disp_scheduler;

  localparam int N    = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  hex_mode = '0;
  logic [31:0] data = '0;
  logic        advance = 1'b0;
  logic [3:0]  grant;
  logic [7:0]  disp_val;
  logic        disp_hex;
  logic        disp_en;
  logic [2:0]  dwell_cnt;

  int checks = 0;
  int errors = 0;

  disp_scheduler #(.N_REQ(N), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .hex_mode  (hex_mode),
    .data      (data),
    .advance   (advance),
    .grant     (grant),
    .disp_val  (disp_val),
    .disp_hex  (disp_hex),
    .disp_en   (disp_en),
    .dwell_cnt (dwell_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = idle), round-robin pointer, dwell count, display regs.
  int         m_owner;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_val;
  logic       m_hex;
  logic       m_en;

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int w;
    if (!reset_n) begin
      m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_val = 8'h00; m_hex = 1'b0; m_en = 1'b0;
    end else if (m_owner >= 0 && !(m_cnt == HOLD - 1 || advance || !req[m_owner])) begin
      m_cnt = m_cnt + 1;
      m_val = data[8*m_owner +: 8];
      m_hex = hex_mode[m_owner];
    end else begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_cnt = 0; m_en = 1'b1;
        m_val = data[8*w +: 8];
        m_hex = hex_mode[w];
      end else begin
        m_owner = -1; m_cnt = 0; m_en = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; advance = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0 || disp_en !== 1'b0 || disp_val !== 8'h00 || disp_hex !== 1'b0 ||
        dwell_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: got grant=%b en=%b val=%h hex=%b cnt=%0d required all 0",
               grant, disp_en, disp_val, disp_hex, dwell_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b0001; data = 32'h0000_0011;
    repeat (4) @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || disp_val !== 8'h11) begin
      errors++;
      $display("FAIL reset_pre_show: got grant=%b val=%h required 0001 11", grant, disp_val);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0 || disp_en !== 1'b0 || disp_val !== 8'h00 || dwell_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got grant=%b en=%b val=%h cnt=%0d required 0 0 00 0",
               grant, disp_en, disp_val, dwell_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || disp_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_grant: got grant=%b en=%b required 0001 1", grant, disp_en);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [4];
    logic [7:0] vals  [4];
    order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    vals  = '{8'h11, 8'h22, 8'h44, 8'h11};
    do_reset();
    req = 4'b1011; hex_mode = 4'b0000; data = 32'h44_33_22_11;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== order[c/8] || disp_val !== vals[c/8] || dwell_cnt !== 3'(c % 8)) begin
        errors++;
        $display("FAIL round_robin c=%0d: got grant=%b val=%h cnt=%0d required %b %h %0d",
                 c, grant, disp_val, dwell_cnt, order[c/8], vals[c/8], c % 8);
      end
    end
  endtask

  task automatic test_advance();
    do_reset();
    req = 4'b0011; data = 32'h00_00_BB_AA;
    for (int c = 0; c < 4; c++) @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || dwell_cnt !== 3'd3) begin
      errors++;
      $display("FAIL advance_pre: got grant=%b cnt=%0d required 0001 3", grant, dwell_cnt);
    end
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    checks++;
    if (grant !== 4'b0010 || dwell_cnt !== 3'd0 || disp_val !== 8'hBB) begin
      errors++;
      $display("FAIL advance_switch: got grant=%b cnt=%0d val=%h required 0010 0 bb",
               grant, dwell_cnt, disp_val);
    end
    for (int c = 1; c < 8; c++) @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || dwell_cnt !== 3'd7) begin
      errors++;
      $display("FAIL advance_pre_expiry: got grant=%b cnt=%0d required 0010 7", grant, dwell_cnt);
    end
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    checks++;
    if (grant !== 4'b0001 || dwell_cnt !== 3'd0) begin
      errors++;
      $display("FAIL advance_with_expiry: got grant=%b cnt=%0d required 0001 0", grant, dwell_cnt);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || dwell_cnt !== 3'd1) begin
      errors++;
      $display("FAIL advance_single_switch: got grant=%b cnt=%0d required 0001 1",
               grant, dwell_cnt);
    end
  endtask

  task automatic test_sole_drop();
    do_reset();
    req = 4'b0100; data = 32'h00_5A_00_00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0100 || dwell_cnt !== 3'(c % 8) || disp_en !== 1'b1) begin
        errors++;
        $display("FAIL sole c=%0d: got grant=%b cnt=%0d en=%b required 0100 %0d 1",
                 c, grant, dwell_cnt, disp_en, c % 8);
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || disp_en !== 1'b0 || disp_val !== 8'h5A) begin
      errors++;
      $display("FAIL drop_idle: got grant=%b en=%b val=%h required 0000 0 5a",
               grant, disp_en, disp_val);
    end
  endtask

  task automatic test_format();
    do_reset();
    req = 4'b0001; hex_mode = 4'b0001; data = 32'h00_00_F6_7F;
    @(negedge clk);
    checks++;
    if (disp_val !== 8'h7F || disp_hex !== 1'b1) begin
      errors++;
      $display("FAIL fmt_hex: got val=%h hex=%b required 7f 1", disp_val, disp_hex);
    end
    data[7:0] = 8'h80;
    @(negedge clk);
    checks++;
    if (disp_val !== 8'h80 || disp_hex !== 1'b1) begin
      errors++;
      $display("FAIL fmt_live: got val=%h hex=%b required 80 1", disp_val, disp_hex);
    end
    req = 4'b0011; advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    checks++;
    if (grant !== 4'b0010 || disp_val !== 8'hF6 || disp_hex !== 1'b0) begin
      errors++;
      $display("FAIL fmt_dec: got grant=%b val=%h hex=%b required 0010 f6 0",
               grant, disp_val, disp_hex);
    end
  endtask

  task automatic test_idle_noise();
    do_reset();
    hex_mode = 4'b1111; data = 32'hDEAD_BEEF;
    for (int c = 0; c < 20; c++) begin
      advance = (c % 3 == 0);
      @(negedge clk);
      checks++;
      if (grant !== 4'b0 || disp_en !== 1'b0 || disp_val !== 8'h00 || disp_hex !== 1'b0 ||
          dwell_cnt !== 3'd0) begin
        errors++;
        $display("FAIL idle_noise c=%0d: got grant=%b en=%b val=%h hex=%b cnt=%0d required 0",
                 c, grant, disp_en, disp_val, disp_hex, dwell_cnt);
      end
    end
    advance = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      if ($urandom_range(15) == 0) hex_mode = 4'($urandom);
      if ($urandom_range(3) == 0) data = $urandom;
      advance = ($urandom_range(15) == 0);
      @(negedge clk);
      checks++;
      if (grant !== m_grant() || disp_en !== m_en || disp_val !== m_val ||
          disp_hex !== m_hex || dwell_cnt !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL random c=%0d: got g=%b en=%b v=%h h=%b n=%0d required %b %b %h %b %0d",
                 c, grant, disp_en, disp_val, disp_hex, dwell_cnt,
                 m_grant(), m_en, m_val, m_hex, m_cnt);
      end
    end
    advance = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_advance();
    test_sole_drop();
    test_format();
    test_idle_noise();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
